// File: rtl/spi_slave_shift_pkg.sv
// spi_slave_shift_pkg: shared types and constants for the SPI mode-0 slave shifter
package spi_slave_shift_pkg;
  localparam int DATA_W_DEF = 8;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/spi_slave_shift_if.sv
// spi_slave_shift_if: SPI pins plus local TX/RX ports of the slave shifter
interface spi_slave_shift_if
  import spi_slave_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic sclk, cs_n, mosi, miso, miso_oe;
  logic tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [DATA_W-1:0] tx_data, rx_data;
  modport slave (
    input sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_shift_sync_ff.sv
// spi_sync_ff: multi-stage synchronizer with async reset to a chosen idle level
module spi_sync_ff #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or posedge reset)
    if (reset) r <= {STAGES{RST_VAL}};
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI mode-0 slave, pins oversampled in clk, full-duplex MSB-first shifter
module spi_slave_shift
  import spi_slave_shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX = '1
) (
  input logic clk,
  input logic reset,
  spi_slave_shift_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  logic s_sclk, s_cs_n, s_mosi, sclk_d, cs_n_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, hold_full;
  logic [DATA_W-1:0] hold, tx_sh, rx_sh;
  logic [CNT_W-1:0] bit_cnt;
  state_t state;
  spi_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk, .reset, .d(bus.sclk), .q(s_sclk));
  spi_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_n (.clk, .reset, .d(bus.cs_n), .q(s_cs_n));
  spi_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk, .reset, .d(bus.mosi), .q(s_mosi));
  assign sclk_rise = s_sclk & ~sclk_d;
  assign sclk_fall = ~s_sclk & sclk_d;
  assign cs_fall = ~s_cs_n & cs_n_d;
  assign cs_rise = s_cs_n & ~cs_n_d;
  assign bus.tx_ready = ~hold_full;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sclk_d <= 1'b0;
      cs_n_d <= 1'b1;
      state <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      tx_sh <= '0;
      rx_sh <= '0;
      bit_cnt <= '0;
      bus.miso <= 1'b0;
      bus.miso_oe <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
      bus.tx_underrun <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      sclk_d <= s_sclk;
      cs_n_d <= s_cs_n;
      bus.rx_valid <= 1'b0;
      bus.tx_underrun <= 1'b0;
      if (bus.tx_valid && !hold_full) begin
        hold <= bus.tx_data;
        hold_full <= 1'b1;
      end
      // a completed word is delivered even if cs_n rises in the same clk
      if (state == DONE) begin
        bus.rx_data <= rx_sh;
        bus.rx_valid <= 1'b1;
      end
      if (cs_rise) begin
        state <= IDLE;
        bit_cnt <= '0;
        bus.miso <= 1'b0;
        bus.miso_oe <= 1'b0;
        bus.busy <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (cs_fall) begin
            state <= LOAD;
            bus.busy <= 1'b1;
          end
          LOAD: begin
            tx_sh <= hold_full ? hold : IDLE_TX;
            bus.miso <= hold_full ? hold[DATA_W-1] : IDLE_TX[DATA_W-1];
            bus.miso_oe <= 1'b1;
            bus.tx_underrun <= ~hold_full;
            if (hold_full) hold_full <= 1'b0;
            bit_cnt <= '0;
            state <= SHIFT;
          end
          SHIFT: if (sclk_rise) begin
            rx_sh <= {rx_sh[DATA_W-2:0], s_mosi};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) state <= DONE;
          end else if (sclk_fall && bit_cnt != '0) begin
            // bit_cnt==0 filters the trailing fall of a previous back-to-back frame
            tx_sh <= tx_sh << 1;
            bus.miso <= tx_sh[DATA_W-2];
          end
          DONE: state <= LOAD;
        endcase
      end
    end
endmodule

// File: tb/tb_spi_slave_shift.sv
// tb_spi_slave_shift: directed scenario tests of the SPI mode-0 slave shifter
module tb_spi_slave_shift;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  spi_slave_shift_if #(.DATA_W(8)) bus ();
  spi_slave_shift dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int passed = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int rxv_base, und_base;
  logic [7:0] got, g1, g2;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rxv_cnt++;
    if (bus.tx_underrun === 1'b1) und_cnt++;
  end

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] mw, input int nbits, output logic [7:0] sw);
    sw = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mw[7-i];
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      sw[7-i] = bus.miso;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.miso !== 1'b0) $display("FAIL reset_miso got %b exp 0", bus.miso); else passed++;
    checks++; if (bus.miso_oe !== 1'b0) $display("FAIL reset_miso_oe got %b exp 0", bus.miso_oe); else passed++;
    checks++; if (bus.tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", bus.tx_ready); else passed++;
    checks++; if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", bus.rx_data); else passed++;
    checks++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", bus.rx_valid); else passed++;
    checks++; if (bus.tx_underrun !== 1'b0) $display("FAIL reset_underrun got %b exp 0", bus.tx_underrun); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else passed++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    load_tx(8'hA5);
    checks++; if (bus.tx_ready !== 1'b0) $display("FAIL basic_ready_full got %b exp 0", bus.tx_ready); else passed++;
    rxv_base = rxv_cnt; und_base = und_cnt;
    cs_low();
    checks++; if (bus.tx_ready !== 1'b1) $display("FAIL basic_ready_after_load got %b exp 1", bus.tx_ready); else passed++;
    checks++; if (und_cnt - und_base !== 0) $display("FAIL basic_underrun got %0d exp 0", und_cnt - und_base); else passed++;
    checks++; if (bus.miso_oe !== 1'b1) $display("FAIL basic_miso_oe got %b exp 1", bus.miso_oe); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", bus.busy); else passed++;
    xfer(8'h3C, 8, got);
    cs_high();
    checks++; if (got !== 8'hA5) $display("FAIL basic_miso_word got %h exp a5", got); else passed++;
    checks++; if (bus.rx_data !== 8'h3C) $display("FAIL basic_rx_data got %h exp 3c", bus.rx_data); else passed++;
    checks++; if (rxv_cnt - rxv_base !== 1) $display("FAIL basic_rx_valid_pulses got %0d exp 1", rxv_cnt - rxv_base); else passed++;
  endtask

  task automatic test_abort();
    load_tx(8'h5A);
    rxv_base = rxv_cnt;
    cs_low();
    xfer(8'hFF, 3, got);
    cs_high();
    checks++; if (rxv_cnt - rxv_base !== 0) $display("FAIL abort_rx_valid got %0d exp 0", rxv_cnt - rxv_base); else passed++;
    checks++; if (bus.rx_data !== 8'h3C) $display("FAIL abort_rx_data got %h exp 3c", bus.rx_data); else passed++;
    checks++; if (bus.miso_oe !== 1'b0) $display("FAIL abort_miso_oe got %b exp 0", bus.miso_oe); else passed++;
    checks++; if (bus.miso !== 1'b0) $display("FAIL abort_miso got %b exp 0", bus.miso); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else passed++;
    checks++; if (bus.tx_ready !== 1'b1) $display("FAIL abort_tx_ready got %b exp 1", bus.tx_ready); else passed++;
  endtask

  task automatic test_underrun();
    rxv_base = rxv_cnt; und_base = und_cnt;
    cs_low();
    checks++; if (und_cnt - und_base !== 1) $display("FAIL underrun_pulses got %0d exp 1", und_cnt - und_base); else passed++;
    xfer(8'h00, 8, got);
    cs_high();
    checks++; if (got !== 8'hFF) $display("FAIL underrun_miso_word got %h exp ff", got); else passed++;
    checks++; if (bus.rx_data !== 8'h00) $display("FAIL underrun_rx_data got %h exp 00", bus.rx_data); else passed++;
    checks++; if (rxv_cnt - rxv_base !== 1) $display("FAIL underrun_rx_valid got %0d exp 1", rxv_cnt - rxv_base); else passed++;
  endtask

  task automatic test_no_overwrite();
    load_tx(8'h55);
    @(negedge clk);
    bus.tx_data = 8'h77;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    checks++; if (bus.tx_ready !== 1'b0) $display("FAIL noovr_ready got %b exp 0", bus.tx_ready); else passed++;
    cs_low();
    xfer(8'h9E, 8, got);
    cs_high();
    checks++; if (got !== 8'h55) $display("FAIL noovr_miso_word got %h exp 55", got); else passed++;
    checks++; if (bus.rx_data !== 8'h9E) $display("FAIL noovr_rx_data got %h exp 9e", bus.rx_data); else passed++;
    checks++; if (bus.tx_ready !== 1'b1) $display("FAIL noovr_ready_after got %b exp 1", bus.tx_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    load_tx(8'hA5);
    rxv_base = rxv_cnt;
    cs_low();
    load_tx(8'hC3);
    xfer(8'h12, 8, g1);
    checks++; if (bus.rx_data !== 8'h12) $display("FAIL b2b_rx_data1 got %h exp 12", bus.rx_data); else passed++;
    xfer(8'h34, 8, g2);
    cs_high();
    checks++; if (g1 !== 8'hA5) $display("FAIL b2b_miso_word1 got %h exp a5", g1); else passed++;
    checks++; if (g2 !== 8'hC3) $display("FAIL b2b_miso_word2 got %h exp c3", g2); else passed++;
    checks++; if (bus.rx_data !== 8'h34) $display("FAIL b2b_rx_data2 got %h exp 34", bus.rx_data); else passed++;
    checks++; if (rxv_cnt - rxv_base !== 2) $display("FAIL b2b_rx_valid_pulses got %0d exp 2", rxv_cnt - rxv_base); else passed++;
  endtask

  task automatic test_reset_mid();
    load_tx(8'h66);
    cs_low();
    load_tx(8'h99);
    xfer(8'hF0, 4, got);
    checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before got %b exp 1", bus.busy); else passed++;
    checks++; if (bus.tx_ready !== 1'b0) $display("FAIL mid_ready_before got %b exp 0", bus.tx_ready); else passed++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.miso !== 1'b0) $display("FAIL mid_miso got %b exp 0", bus.miso); else passed++;
    checks++; if (bus.miso_oe !== 1'b0) $display("FAIL mid_miso_oe got %b exp 0", bus.miso_oe); else passed++;
    checks++; if (bus.tx_ready !== 1'b1) $display("FAIL mid_tx_ready got %b exp 1", bus.tx_ready); else passed++;
    checks++; if (bus.rx_data !== 8'h00) $display("FAIL mid_rx_data got %h exp 00", bus.rx_data); else passed++;
    checks++; if (bus.rx_valid !== 1'b0) $display("FAIL mid_rx_valid got %b exp 0", bus.rx_valid); else passed++;
    checks++; if (bus.tx_underrun !== 1'b0) $display("FAIL mid_underrun got %b exp 0", bus.tx_underrun); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", bus.busy); else passed++;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    rxv_base = rxv_cnt; und_base = und_cnt;
    cs_low();
    xfer(8'hC7, 8, got);
    cs_high();
    checks++; if (got !== 8'hFF) $display("FAIL mid_after_miso_word got %h exp ff", got); else passed++;
    checks++; if (bus.rx_data !== 8'hC7) $display("FAIL mid_after_rx_data got %h exp c7", bus.rx_data); else passed++;
    checks++; if (rxv_cnt - rxv_base !== 1) $display("FAIL mid_after_rx_valid got %0d exp 1", rxv_cnt - rxv_base); else passed++;
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    test_reset();
    test_basic();
    test_abort();
    test_underrun();
    test_no_overwrite();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
